charge_sum: RTL and testbench
=============================

# charge_sum

Accumulates the baseline-subtracted high-gain samples of each triggered frame into one signed charge value. Sits directly downstream of `data_trigger` and consumes its `M_AXIS_TVALID` frame envelope, the frame timestamp and `H_GAIN_BASELINE_SUBTRACTED_TDATA`. Emits one result word per frame on an AXI4-Stream master with a single-entry output buffer. Frames that arrive while the buffer is blocked are dropped and counted.

## Interface

- `SAMPLE_NUM_PER_CLK`, default 8: samples per beat; must be a power of 2.
- `SAMPLE_WIDTH`, default 16: width of one two's-complement sample.
- `TIMESTAMP_WIDTH`, default 48: width of the frame timestamp.
- `CHARGE_WIDTH`, default 32: width of the signed charge accumulator.
- `BEAT_CNT_WIDTH`, default 16: width of the beat counter.
- `ACLK` input, 1 bit: clock.
- `ARESET` input, 1 bit: reset; synchronous, active-high; clock ACLK.
- `STOP` input, 1 bit: high means ignore input and abort any open frame.
- `S_AXIS_TVALID` input, 1 bit: frame envelope from `data_trigger`. A frame is one contiguous run of high cycles.
- `S_TIMESTAMP` input, `TIMESTAMP_WIDTH` bits: timestamp field of the `data_trigger` output word.
- `H_GAIN_BASELINE_SUBTRACTED_TDATA` input, `SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH` bits: signed samples, aligned with `S_AXIS_TVALID`. Sample 0 is in the LSBs.
- `M_AXIS_TDATA` output, `CHARGE_WIDTH+TIMESTAMP_WIDTH+BEAT_CNT_WIDTH` bits: {charge, timestamp, beat_count}, with charge in the MSBs.
- `M_AXIS_TVALID` output, 1 bit: result valid.
- `M_AXIS_TREADY` input, 1 bit: downstream ready.
- `DROP_COUNT` output, 16 bits: number of frames dropped; saturates at 0xFFFF.

## Operation

- **Input side.**
  - There is no input ready signal; input is never back-pressured.
  - Stage 1 adds the `SAMPLE_NUM_PER_CLK` sign-extended samples of a beat into a registered partial sum `psum` of width `SAMPLE_WIDTH+log2(SAMPLE_NUM_PER_CLK)`.
  - A valid flag and a frame-end flag travel with `psum`.
- **Frame detection.**
  - First beat: `S_AXIS_TVALID`=1 while the registered previous TVALID=0. This beat latches `S_TIMESTAMP`, clears the accumulator and sets the beat count to 1.
  - Frame end: `S_AXIS_TVALID`=0 while the previous TVALID=1.
- **Stage 2.**
  - Each valid beat sign-extends `psum` to `CHARGE_WIDTH` and adds it to `acc`.
  - The beat count increments on each beat and saturates at all-ones.
- **Output.**
  - When the end flag reaches stage 2, the final `acc+psum` is loaded into the output buffer together with the timestamp and count.
  - If the buffer is occupied and not being accepted in that cycle, the result is discarded and `DROP_COUNT` increments.
  - Buffer states are EMPTY and FULL:
    - EMPTY to FULL on load.
    - FULL to EMPTY on `M_AXIS_TVALID && M_AXIS_TREADY` with no new load.
    - FULL stays FULL when a handshake and a load occur in the same cycle; the new result replaces the old one with no drop.
  - `M_AXIS_TDATA` is held stable while `M_AXIS_TVALID`=1 and `M_AXIS_TREADY`=0.
- **STOP.**
  - While `STOP`=1, input beats are ignored and pipeline valid/end flags are cleared; an open frame is discarded with no output and no drop count.
  - A frame whose TVALID run starts while `STOP`=1 is not captured, even after `STOP` falls.
  - Capture resumes at the next first beat seen after `STOP` falls.
  - The output buffer and `DROP_COUNT` are unaffected by `STOP`.
- **Reset values.** Synchronous reset clears the pipeline, the accumulator and the frame state.
  - `M_AXIS_TVALID`=0.
  - `M_AXIS_TDATA`=0.
  - `DROP_COUNT`=0.
  - A frame open at reset is lost.

## Timing

- Let L be the edge that samples the last beat of a frame (TVALID=1). At edge L+1, TVALID=0 is sampled.
- `M_AXIS_TVALID` rises after edge L+2: a fixed latency of 2 cycles from the last beat.
- A single-beat frame is legal: charge = sum of that beat, count = 1.
- Back-to-back frames need at least one TVALID-low cycle between them, which the frame definition guarantees. The pipeline accepts a new first beat at L+1.
- Throughput: one result per 2 cycles at best (1-beat frame plus 1 gap cycle). Downstream `TREADY` must keep up to avoid drops.

## Configuration

- `CHARGE_SUM_SATURATION_EN`:
  - **Defined:** the stage-2 add saturates to the signed `CHARGE_WIDTH` limits (0x7FFFFFFF / 0x80000000 at default width) and stays saturated until frame end.
  - **Undefined:** the add wraps modulo 2^`CHARGE_WIDTH`.

## Test plan

- **Basic sum.** Reset, then a 3-beat frame with all samples = 100 and timestamp 0x10 -> one output with charge 2400, timestamp 0x10, count 3, `M_AXIS_TVALID` high 2 cycles after the last beat.
- **Mixed signs, back-to-back.** Frame A: 2 beats, samples alternating +50/-30 -> charge 160. One idle cycle, then frame B: 1 beat, all samples -1 -> charge -8. Both results are delivered in order with `TREADY`=1.
- **Back-pressure drop.** Hold `TREADY`=0 across three 1-beat frames -> the first result stays held and stable, the other two are dropped, `DROP_COUNT`=2. Raise `TREADY` -> the first result is accepted and `TVALID` falls.
- **STOP mid-frame.** Assert `STOP` on beat 2 of a 4-beat frame -> no output and `DROP_COUNT` unchanged. A following 1-beat frame after `STOP` falls produces a correct result.
- **Reset mid-frame.** Pulse `ARESET` during beat 3 of 5 -> `M_AXIS_TVALID`=0 and no output for that frame. The next frame is correct.
- **Saturation.** 16-bit samples all 0x7FFF for 20000 beats -> with `CHARGE_SUM_SATURATION_EN` defined, charge = 0x7FFFFFFF; without it, charge is the wrapped value and count = 20000.

Source files
------------

// File: rtl/charge_sum.sv
// charge_sum: per-frame sum of baseline-subtracted high-gain samples.
// Optional CHARGE_SUM_SATURATION_EN makes the accumulator saturate instead of wrap.
module charge_sum #(
    parameter int SAMPLE_NUM_PER_CLK = 8,
    parameter int SAMPLE_WIDTH       = 16,
    parameter int TIMESTAMP_WIDTH    = 48,
    parameter int CHARGE_WIDTH       = 32,
    parameter int BEAT_CNT_WIDTH     = 16
) (
    input  logic                                       ACLK,
    input  logic                                       ARESET,
    input  logic                                       STOP,
    input  logic                                       S_AXIS_TVALID,
    input  logic [TIMESTAMP_WIDTH-1:0]                 S_TIMESTAMP,
    input  logic [SAMPLE_NUM_PER_CLK*SAMPLE_WIDTH-1:0] H_GAIN_BASELINE_SUBTRACTED_TDATA,
    output logic [CHARGE_WIDTH+TIMESTAMP_WIDTH+BEAT_CNT_WIDTH-1:0] M_AXIS_TDATA,
    output logic                                       M_AXIS_TVALID,
    input  logic                                       M_AXIS_TREADY,
    output logic [15:0]                                DROP_COUNT
);

    localparam int PW = SAMPLE_WIDTH + $clog2(SAMPLE_NUM_PER_CLK);
    localparam int CW = CHARGE_WIDTH;
    localparam int OW = CHARGE_WIDTH + TIMESTAMP_WIDTH + BEAT_CNT_WIDTH;

    typedef enum logic {EMPTY, FULL} state_t;

    logic                        r_prev_tvalid;
    logic                        r_open;
    logic signed [PW-1:0]        r_psum;
    logic                        r_p_valid;
    logic                        r_p_first;
    logic                        r_p_end;
    logic [TIMESTAMP_WIDTH-1:0]  r_ts;
    logic signed [CW-1:0]        r_acc;
    logic [BEAT_CNT_WIDTH-1:0]   r_cnt;
    logic                        r_sat;
    state_t                      r_state;
    logic [OW-1:0]               r_tdata;
    logic [15:0]                 r_drop;

    logic signed [PW-1:0]        w_beat_sum;
    logic                        w_first;
    logic                        w_beat;
    logic                        w_end;
    logic signed [CW-1:0]        w_psum_ext;
    logic signed [CW-1:0]        w_base;
    logic signed [CW-1:0]        w_sum;
    logic                        w_sat_nxt;
    logic                        w_load;
    logic                        w_take;
    logic                        w_drop;
    state_t                      w_state_nxt;

    // Stage 1: adder tree over the beat's samples
    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < SAMPLE_NUM_PER_CLK; i++) begin
            w_beat_sum = w_beat_sum + PW'(signed'(
                H_GAIN_BASELINE_SUBTRACTED_TDATA[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
        end
    end

    assign w_first = S_AXIS_TVALID & ~r_prev_tvalid & ~STOP;
    assign w_beat  = S_AXIS_TVALID & ~STOP & (r_open | w_first);
    assign w_end   = ~S_AXIS_TVALID & r_prev_tvalid & r_open & ~STOP;

    // Previous TVALID resets high so a run already in progress is not taken as a new frame
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_prev_tvalid <= 1'b1;
            r_open        <= 1'b0;
            r_psum        <= '0;
            r_p_valid     <= 1'b0;
            r_p_first     <= 1'b0;
            r_p_end       <= 1'b0;
            r_ts          <= '0;
        end else begin
            r_prev_tvalid <= S_AXIS_TVALID;
            if (STOP)
                r_open <= 1'b0;
            else if (w_first)
                r_open <= 1'b1;
            else if (w_end)
                r_open <= 1'b0;
            r_psum    <= w_beat ? w_beat_sum : '0;
            r_p_valid <= w_beat;
            r_p_first <= w_first;
            r_p_end   <= w_end;
            if (w_first)
                r_ts <= S_TIMESTAMP;
        end
    end

    // Stage 2: frame accumulator
    assign w_psum_ext = CW'(r_psum);
    assign w_base     = r_p_first ? '0 : r_acc;

`ifdef CHARGE_SUM_SATURATION_EN
    logic signed [CW:0] w_wide;
    logic               w_ovf;
    logic               w_hold;

    assign w_wide = (CW+1)'(w_base) + (CW+1)'(w_psum_ext);
    assign w_ovf  = w_wide[CW] != w_wide[CW-1];
    assign w_hold = r_sat & ~r_p_first;

    always_comb begin
        w_sat_nxt = w_hold;
        w_sum     = w_wide[CW-1:0];
        if (w_hold) begin
            w_sum = r_acc;
        end else if (w_ovf) begin
            w_sat_nxt = 1'b1;
            w_sum     = w_wide[CW] ? {1'b1, {(CW-1){1'b0}}}
                                   : {1'b0, {(CW-1){1'b1}}};
        end
    end
`else
    assign w_sum     = w_base + w_psum_ext;
    assign w_sat_nxt = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (!STOP && r_p_valid) begin
            r_acc <= w_sum;
            r_sat <= w_sat_nxt;
            if (r_p_first)
                r_cnt <= BEAT_CNT_WIDTH'(1);
            else if (r_cnt != '1)
                r_cnt <= r_cnt + BEAT_CNT_WIDTH'(1);
        end
    end

    // Output buffer: psum is zero on the end cycle, so w_sum is the final charge
    assign w_load = r_p_end & ~STOP;

    always_ff @(posedge ACLK) begin
        if (ARESET)
            r_state <= EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: if (w_load) w_state_nxt = FULL;
            FULL:  if (!w_load && M_AXIS_TREADY) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        M_AXIS_TVALID = (r_state == FULL);
        w_take = w_load & ((r_state == EMPTY) | M_AXIS_TREADY);
        w_drop = w_load & (r_state == FULL) & ~M_AXIS_TREADY;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_tdata <= '0;
            r_drop  <= '0;
        end else begin
            if (w_take)
                r_tdata <= {w_sum, r_ts, r_cnt};
            if (w_drop && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;
        end
    end

    assign M_AXIS_TDATA = r_tdata;
    assign DROP_COUNT   = r_drop;

endmodule

// File: tb/tb_charge_sum.sv
// Self-checking bench for charge_sum: vector table plus corner-case sequences.
// Build with CHARGE_SUM_SATURATION_EN to exercise the saturating accumulator.
module tb_charge_sum;

    localparam int N  = 8;
    localparam int SW = 16;
    localparam int TW = 48;
    localparam int CW = 32;
    localparam int BW = 16;
    localparam int OW = CW + TW + BW;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          STOP = 1'b0;
    logic          tv = 1'b0;
    logic [TW-1:0] ts = '0;
    logic [N*SW-1:0] hd = '0;
    logic [OW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY = 1'b1;
    logic [15:0]   DROP_COUNT;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [TW-1:0] ts;
        logic [BW-1:0] cnt;
    } exp_t;

    typedef struct {
        int            nb;
        int            se;
        int            so;
        logic [TW-1:0] ts;
        int            ch;
    } vec_t;

    exp_t sb[$];

    charge_sum dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .STOP(STOP),
        .S_AXIS_TVALID(tv),
        .S_TIMESTAMP(ts),
        .H_GAIN_BASELINE_SUBTRACTED_TDATA(hd),
        .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .DROP_COUNT(DROP_COUNT)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Scoreboard: pop on every accepted output word
    always @(negedge ACLK) begin
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_out: got %0h want none", M_AXIS_TDATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("charge", 128'(M_AXIS_TDATA[OW-1 -: CW]), 128'(e.ch));
                chk("tstamp", 128'(M_AXIS_TDATA[BW +: TW]), 128'(e.ts));
                chk("count", 128'(M_AXIS_TDATA[BW-1:0]), 128'(e.cnt));
            end
        end
    end

    task automatic set_beat(int se, int so);
        logic [SW-1:0] ve;
        logic [SW-1:0] vo;
        ve = se[SW-1:0];
        vo = so[SW-1:0];
        for (int k = 0; k < N; k++)
            hd[k*SW +: SW] = (k % 2 == 0) ? ve : vo;
    endtask

    task automatic send(int nb, int se, int so, logic [TW-1:0] t,
                        bit push, logic [CW-1:0] ex);
        if (push)
            sb.push_back('{ch: ex, ts: t, cnt: BW'(nb)});
        for (int b = 0; b < nb; b++) begin
            @(posedge ACLK); #1;
            tv = 1'b1;
            ts = t;
            set_beat(se, so);
        end
        @(posedge ACLK); #1;
        tv = 1'b0;
        ts = '0;
        hd = '0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            if (sb.size() == 0 && !M_AXIS_TVALID)
                break;
            @(negedge ACLK);
        end
        chk("drain", 128'(sb.size()), 128'(0));
    endtask

    vec_t vecs[5];
    logic [63:0] big;
    logic [CW-1:0] sat_exp;

    initial begin
        vecs[0] = '{nb: 2, se: 50,     so: -30,   ts: 48'h20, ch: 160};
        vecs[1] = '{nb: 1, se: -1,     so: -1,    ts: 48'h21, ch: -8};
        vecs[2] = '{nb: 4, se: -32768, so: 32767, ts: 48'h30, ch: -16};
        vecs[3] = '{nb: 1, se: 32767,  so: 32767, ts: 48'h31, ch: 262136};
        vecs[4] = '{nb: 5, se: 3,      so: 1,     ts: 48'hABCDEF012345, ch: 80};

        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_tvalid", 128'(M_AXIS_TVALID), 128'(0));
        chk("rst_tdata", 128'(M_AXIS_TDATA), 128'(0));
        chk("rst_drop", 128'(DROP_COUNT), 128'(0));

        // Basic sum with latency check
        send(3, 100, 100, 48'h10, 1'b1, 32'd2400);
        @(negedge ACLK);
        @(negedge ACLK);
        chk("lat_l1", 128'(M_AXIS_TVALID), 128'(0));
        @(negedge ACLK);
        chk("lat_l2", 128'(M_AXIS_TVALID), 128'(1));
        wait_idle();

        // Vector table, frames back to back
        foreach (vecs[i])
            send(vecs[i].nb, vecs[i].se, vecs[i].so, vecs[i].ts,
                 1'b1, CW'(vecs[i].ch));
        wait_idle();

        // Back-pressure: first result held, next two dropped
        M_AXIS_TREADY = 1'b0;
        send(1, 7, 7, 48'h40, 1'b1, 32'd56);
        send(1, 8, 8, 48'h41, 1'b0, 32'd0);
        send(1, 9, 9, 48'h42, 1'b0, 32'd0);
        repeat (3) @(negedge ACLK);
        chk("bp_valid", 128'(M_AXIS_TVALID), 128'(1));
        chk("bp_hold1", 128'(M_AXIS_TDATA), 128'({32'd56, 48'h40, 16'd1}));
        chk("bp_drop", 128'(DROP_COUNT), 128'(2));
        repeat (2) @(negedge ACLK);
        chk("bp_hold2", 128'(M_AXIS_TDATA), 128'({32'd56, 48'h40, 16'd1}));
        @(posedge ACLK); #1;
        M_AXIS_TREADY = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("bp_fall", 128'(M_AXIS_TVALID), 128'(0));
        chk("bp_sb", 128'(sb.size()), 128'(0));

        // STOP on beat 2 of a 4-beat frame
        @(posedge ACLK); #1;
        tv = 1'b1; ts = 48'h50; set_beat(5, 5);
        @(posedge ACLK); #1 STOP = 1'b1;
        @(posedge ACLK); #1 STOP = 1'b0;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1 tv = 1'b0; hd = '0;
        repeat (5) @(negedge ACLK);
        chk("stop_valid", 128'(M_AXIS_TVALID), 128'(0));
        chk("stop_drop", 128'(DROP_COUNT), 128'(2));
        send(1, 3, 3, 48'h51, 1'b1, 32'd24);
        wait_idle();

        // Reset pulse on beat 3 of 5
        @(posedge ACLK); #1;
        tv = 1'b1; ts = 48'h60; set_beat(4, 4);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1 tv = 1'b0; hd = '0;
        repeat (5) @(negedge ACLK);
        chk("rstf_valid", 128'(M_AXIS_TVALID), 128'(0));
        chk("rstf_drop", 128'(DROP_COUNT), 128'(0));
        send(2, -2, -2, 48'h61, 1'b1, CW'(-32));
        wait_idle();

        // Long frame of full-scale samples
        big = 64'd20000 * 64'd262136;
`ifdef CHARGE_SUM_SATURATION_EN
        sat_exp = 32'h7FFFFFFF;
`else
        sat_exp = big[CW-1:0];
`endif
        send(20000, 32767, 32767, 48'h70, 1'b1, sat_exp);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
